// File: rtl/keypad_scanner_pkg.sv
// Shared constants for the 4x4 keypad scanner: matrix geometry, FSM state
// encodings and the column priority helper.
package keypad_scanner_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int ROW_W      = 2;
    localparam int COL_W      = 2;
    localparam int KEY_CODE_W = ROW_W + COL_W;

    localparam logic [1:0] ST_SCAN    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Lowest-index low column wins when several contacts close on one row.
    function automatic logic [COL_W-1:0] lowest_low(input logic [NUM_COLS-1:0] cols);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) begin
                idx = COL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones so
// pulled-up lines read as idle.
module keypad_scanner_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= {WIDTH{1'b1}};
            q    <= {WIDTH{1'b1}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-driving 4x4 keypad scanner: walks a low row across the matrix, debounces
// the first contact found and reports one key code per press.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int          ROW_SETTLE      = 6,
    parameter logic [31:0] DEBOUNCE_PERIOD = 32'd120000
) (
    input  logic                  hwclk,
    input  logic                  rst,
    output logic [NUM_ROWS-1:0]   keypad_r,
    input  logic [NUM_COLS-1:0]   keypad_c_din,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam int SETTLE_W = (ROW_SETTLE > 1) ? $clog2(ROW_SETTLE) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(ROW_SETTLE - 1);
    localparam logic [31:0] DEBOUNCE_LAST = DEBOUNCE_PERIOD - 32'd1;

    logic [NUM_COLS-1:0] cs;
    logic [1:0]          state;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [31:0]         debounce_cnt;
    logic                col_low;

    keypad_scanner_sync_2ff #(
        .WIDTH(NUM_COLS)
    ) u_col_sync (
        .clk(hwclk),
        .rst(rst),
        .d  (keypad_c_din),
        .q  (cs)
    );

    // The latched row stays driven through CONFIRM/HELD/RELEASE, so the
    // tracked column is only meaningful against that same row.
    assign keypad_r = ~(NUM_ROWS'(1) << row);
    assign col_low  = ~cs[col];

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state        <= ST_SCAN;
            row          <= '0;
            col          <= '0;
            settle_cnt   <= '0;
            debounce_cnt <= '0;
            key_code     <= '0;
            key_valid    <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        if (cs != {NUM_COLS{1'b1}}) begin
                            col          <= lowest_low(cs);
                            debounce_cnt <= '0;
                            state        <= ST_CONFIRM;
                        end else begin
                            row <= row + ROW_W'(1);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (!col_low) begin
                        row        <= row + ROW_W'(1);
                        settle_cnt <= '0;
                        state      <= ST_SCAN;
                    end else if (debounce_cnt == DEBOUNCE_LAST) begin
                        key_code  <= {row, col};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= ST_HELD;
                    end else begin
                        debounce_cnt <= debounce_cnt + 32'd1;
                    end
                end
                ST_HELD: begin
                    if (!col_low) begin
                        debounce_cnt <= '0;
                        state        <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Any low sample restarts the release window.
                    if (col_low) begin
                        debounce_cnt <= '0;
                    end else if (debounce_cnt == DEBOUNCE_LAST) begin
                        key_held   <= 1'b0;
                        row        <= '0;
                        settle_cnt <= '0;
                        state      <= ST_SCAN;
                    end else begin
                        debounce_cnt <= debounce_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model pulls a column low while
// its row is driven; expected key codes are queued and checked on key_valid.
module tb_keypad_scanner;

    localparam int          RS = 4;
    localparam logic [31:0] DP = 32'd8;

    logic        hwclk = 1'b0;
    logic        rst   = 1'b1;
    logic [3:0]  keypad_r;
    logic [3:0]  keypad_c_din;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic [3:0] idle_rows[4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keypad_scanner #(
        .ROW_SETTLE     (RS),
        .DEBOUNCE_PERIOD(DP)
    ) dut (
        .hwclk       (hwclk),
        .rst         (rst),
        .keypad_r    (keypad_r),
        .keypad_c_din(keypad_c_din),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

    always #5 hwclk = ~hwclk;

    // Pressed key (r,c) grounds column c only while row r is driven low.
    always_comb begin
        keypad_c_din = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !keypad_r[r]) begin
                    keypad_c_din[c] = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d..%0d at %0t", name, actual, lo, hi, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        pressed = keys;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge hwclk);
    endtask

    task automatic waitRow(input logic [3:0] val);
        for (int i = 0; i < 64; i++) begin
            if (keypad_r == val) return;
            @(negedge hwclk);
        end
        checkOutput("wait_row_timeout", {28'd0, keypad_r}, {28'd0, val});
    endtask

    task automatic waitHeld(input logic level, input int max_cycles, output int n);
        n = 0;
        while (key_held !== level && n < max_cycles) begin
            @(negedge hwclk);
            n++;
        end
        if (key_held !== level) begin
            checkOutput("wait_held_timeout", {31'd0, key_held}, {31'd0, level});
        end
    endtask

    // Monitor: every key_valid pops one expected code.
    always @(negedge hwclk) begin
        if (!rst && key_valid) begin
            checkOutput("valid_gap", {31'd0, prev_valid}, 32'd0);
            checkOutput("held_with_valid", {31'd0, key_held}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_valid actual=%0h expected=none at %0t", key_code, $time);
            end else begin
                checkOutput("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        int n;
        rst = 1'b1;
        applyStimulus(16'h0000);
        tick(3);
        checkOutput("reset_row", {28'd0, keypad_r}, 32'hE);
        checkOutput("reset_code", {28'd0, key_code}, 32'h0);
        checkOutput("reset_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("reset_held", {31'd0, key_held}, 32'd0);
        rst = 1'b0;

        waitRow(4'b1101);
        for (int i = 0; i < 16; i++) begin
            checkOutput("idle_row", {28'd0, keypad_r}, {28'd0, idle_rows[i/4]});
            checkOutput("idle_held", {31'd0, key_held}, 32'd0);
            @(negedge hwclk);
        end

        $display("[TB] clean press row2 col1");
        exp_q.push_back(4'h9);
        applyStimulus(16'h0001 << 9);
        waitHeld(1'b1, 100, n);
        for (int i = 0; i < 30; i++) begin
            checkOutput("held_row", {28'd0, keypad_r}, 32'hB);
            @(negedge hwclk);
        end
        applyStimulus(16'h0000);
        waitHeld(1'b0, 30, n);
        checkRange("release_latency", n, 8, 13);
        checkOutput("row_after_release", {28'd0, keypad_r}, 32'hE);

        $display("[TB] bounce on press row1 col2");
        exp_q.push_back(4'h6);
        waitRow(4'b1101);
        applyStimulus(16'h0001 << 6);
        tick(6);
        applyStimulus(16'h0000);
        tick(1);
        applyStimulus(16'h0001 << 6);
        tick(2);
        checkOutput("bounce_abort_row", {28'd0, keypad_r}, 32'hB);
        checkOutput("bounce_no_held", {31'd0, key_held}, 32'd0);
        waitHeld(1'b1, 100, n);
        tick(5);
        applyStimulus(16'h0000);
        waitHeld(1'b0, 30, n);
        checkRange("bounce_press_release", n, 8, 13);

        $display("[TB] bounce on release row3 col0");
        exp_q.push_back(4'hC);
        applyStimulus(16'h0001 << 12);
        waitHeld(1'b1, 100, n);
        tick(4);
        applyStimulus(16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge hwclk);
            checkOutput("rel_bounce_held", {31'd0, key_held}, 32'd1);
        end
        applyStimulus(16'h0001 << 12);
        @(negedge hwclk);
        checkOutput("rel_bounce_low", {31'd0, key_held}, 32'd1);
        applyStimulus(16'h0000);
        for (int i = 0; i < 7; i++) begin
            @(negedge hwclk);
            checkOutput("rel_final_held", {31'd0, key_held}, 32'd1);
        end
        waitHeld(1'b0, 10, n);
        checkRange("rel_final_fall", n, 1, 6);

        $display("[TB] row0 cols 3 and 1 together");
        exp_q.push_back(4'h1);
        applyStimulus(16'h000A);
        waitHeld(1'b1, 100, n);
        tick(3);
        applyStimulus(16'h0000);
        waitHeld(1'b0, 30, n);
        checkRange("multi_release", n, 8, 13);

        $display("[TB] reset during confirm");
        waitRow(4'b1011);
        applyStimulus(16'h0001 << 11);
        tick(7);
        rst = 1'b1;
        tick(1);
        checkOutput("rst_row", {28'd0, keypad_r}, 32'hE);
        checkOutput("rst_held", {31'd0, key_held}, 32'd0);
        checkOutput("rst_code", {28'd0, key_code}, 32'h0);
        checkOutput("rst_valid", {31'd0, key_valid}, 32'd0);
        rst = 1'b0;
        applyStimulus(16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("rst_scan_row0", {28'd0, keypad_r}, 32'hE);
        end
        tick(1);
        checkOutput("rst_scan_row1", {28'd0, keypad_r}, 32'hD);

        tick(20);
        checkOutput("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
